lsu_split_ctrl: RTL and testbench
=================================

// Module: lsu_split_ctrl
// PURPOSE
//  EX-stage load/store controller. Drives the OBI-style data bus (req/gnt/rvalid) and splits misaligned accesses into two word beats.
//  Asserts lsu_addr_incr_req_o for the second beat; the EX operand muxes then select addr_last_o (A) and constant 4 (B).
//  Realigns and extends load data; reports completion and bus errors to writeback/controller.
// PARAMETERS
//  GNT_TIMEOUT  0  cycles waiting for gnt before abort with error; 0 = wait forever
// PORTS
//  clk_i               in   1   clock
//  rst_i               in   1   synchronous active-high reset
//  lsu_req_i           in   1   EX requests an access (sampled only in IDLE)
//  lsu_we_i            in   1   1=store, 0=load
//  lsu_type_i          in   2   lsu_type_e: LSU_WORD/LSU_HALF/LSU_BYTE
//  lsu_sign_ext_i      in   1   sign-extend load result
//  lsu_wdata_i         in   32  store data (unaligned, LSB-justified)
//  adder_result_ex_i   in   32  ALU sum: effective address (beat 1) or addr_last+4 (beat 2)
//  data_req_o          out  1   bus request
//  data_gnt_i          in   1   bus grant
//  data_rvalid_i       in   1   bus response valid
//  data_err_i          in   1   bus error, valid with rvalid
//  data_addr_o         out  32  word-aligned address {adder_result_ex_i[31:2],2'b00}
//  data_we_o           out  1   write enable
//  data_be_o           out  4   byte enables
//  data_wdata_o        out  32  rotated store data
//  data_rdata_i        in   32  read data
//  lsu_addr_incr_req_o out  1   EX operand muxes must form addr_last+4
//  addr_last_o         out  32  registered address of beat 1
//  lsu_rdata_o         out  32  aligned, extended load result
//  lsu_rdata_valid_o   out  1   load result valid (1-cycle pulse)
//  lsu_req_done_o      out  1   access finished, ok or error (1-cycle pulse)
//  load_err_o          out  1   load bus error/timeout (pulse with done)
//  store_err_o         out  1   store bus error/timeout (pulse with done)
//  misaligned_err_o    out  1   misaligned trap (pulse with done; macro only)
//  busy_o              out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; addr_last_o, rdata_q, err/timeout counters 0; all pulse outputs 0. Reset aborts any access; rvalid arriving in IDLE is ignored.
//  - off = adder_result_ex_i[1:0] captured into off_q at accept. split = (WORD & off!=0) | (HALF & off==3). BYTE never splits.
//  - FSM: IDLE, WAIT_GNT_MIS, WAIT_RVALID_MIS, WAIT_GNT, WAIT_RVALID.
//    IDLE: lsu_req_i -> data_req_o=1 same cycle; capture addr_last/type/we/off. gnt -> WAIT_RVALID(_MIS), else WAIT_GNT(_MIS).
//    WAIT_GNT_MIS: req held, addr/be stable; gnt -> WAIT_RVALID_MIS.
//    WAIT_RVALID_MIS: incr_req=1; rvalid&!err -> rdata_q<=rdata, -> WAIT_GNT; rvalid&err -> IDLE, done+err (beat 2 skipped).
//    WAIT_GNT: req=1; incr_req=1 if split; gnt -> WAIT_RVALID.
//    WAIT_RVALID: incr_req=1 if split; rvalid -> IDLE, done pulse; rdata_valid=!err & !we; err -> load/store_err.
//  - One outstanding transaction; beat 2 issued only after beat-1 rvalid. gnt and rvalid never in the same cycle for one beat.
//  - Byte enables, beat1/beat2: WORD off1 1110/0001, off2 1100/0011, off3 1000/0111, off0 1111.
//    HALF off0 0011, off1 0110, off2 1100, off3 1000/0001. BYTE 0001<<off.
//  - data_wdata_o = lsu_wdata_i rotated left by 8*off (same value both beats).
//  - Load align: split -> ({data_rdata_i,rdata_q} >> 8*off)[31:0]; else data_rdata_i >> 8*off.
//    HALF/BYTE then sign- or zero-extended per lsu_sign_ext_i.
//  - Timeout (GNT_TIMEOUT>0): counter runs in WAIT_GNT*, clears on gnt. At GNT_TIMEOUT: drop req, -> IDLE, done + load/store_err.
//  - Latency: aligned access, gnt in request cycle, rvalid next cycle -> done 1 cycle after lsu_req_i.
// CONFIGURATION
//  `LSU_MISALIGN_TRAP_EN defined: split accesses never reach the bus. No req; misaligned_err_o + lsu_req_done_o pulse the cycle after accept; FSM stays IDLE.
//  Undefined: splitting as above; misaligned_err_o tied 0.
// STRUCTURE
//  core_pkg: lsu_type_e, lsu_state_e, BE lookup constants.
//  Sub-module lsu_data_align (combinational): rdata shift/merge/extend. FSM, wdata rotation, BE generation stay in lsu_split_ctrl.
// TESTING
//  - LW addr 0x100, gnt same cycle, rvalid+1, rdata 0xDEADBEEF -> be 1111, lsu_rdata_o 0xDEADBEEF, done 1 cycle after req.
//  - LW addr 0x101: beat1 rdata 0x44332211, beat2 0x88776655 -> be 1110 then 0001; incr_req high from WAIT_RVALID_MIS; result 0x55443322.
//  - SH 0xA5A5 addr 0x203 -> beat1 addr 0x200 be 1000, beat2 addr 0x204 be 0001; wdata 0xA50000A5.
//  - LB signed addr 0x302, rdata 0x00800000 -> be 0100, result 0xFFFFFF80; LBU -> 0x00000080.
//  - Split load, data_err_i on beat1 -> no beat-2 req; done+load_err same cycle; rdata_valid 0.
//  - GNT_TIMEOUT=4, gnt never -> req drops after 4 cycles, store_err pulse. rst_i mid WAIT_RVALID -> IDLE, late rvalid ignored.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - LSU type/state enums, byte-enable masks and split detection
package core_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    function automatic logic [3:0] be_mask(input logic [1:0] lsu_type);
        case (lsu_type)
            LSU_HALF: return BE_HALF;
            LSU_BYTE: return BE_BYTE;
            default:  return BE_WORD;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] lsu_type, input logic [1:0] off);
        case (lsu_type)
            LSU_HALF: return off == 2'd3;
            LSU_BYTE: return 1'b0;
            default:  return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - load data merge, right-align and sign/zero extension
module lsu_data_align
    import core_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] rdata_q_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        split_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o
);

    logic [63:0] merged;
    logic [31:0] shifted;

    always_comb begin
        // Beat 2 supplies the upper bytes; beat 1 was parked in rdata_q.
        merged  = split_i ? {rdata_i, rdata_q_i} : {32'd0, rdata_i};
        shifted = 32'(merged >> {off_i, 3'b000});
        case (lsu_type_i)
            LSU_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            LSU_BYTE: rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            default:  rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_split_ctrl.sv
// rtl/lsu_split_ctrl.sv - EX-stage load/store controller with misaligned split
// Optional macro LSU_MISALIGN_TRAP_EN: trap split accesses instead of issuing two beats.
module lsu_split_ctrl
    import core_pkg::*;
#(
    parameter int unsigned GNT_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        lsu_addr_incr_req_o,
    output logic [31:0] addr_last_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_req_done_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        misaligned_err_o,
    output logic        busy_o
);

    lsu_state_e  state_q;
    logic [31:0] addr_last_q, rdata_q, gnt_cnt_q;
    logic [1:0]  type_q, off_q;
    logic        we_q, sign_q, split_q;

    logic        idle, wait_gnt, beat2, split_cur, accept, gnt_timeout;
    logic        trap_req, trap_done, rvalid_done, beat1_err, bus_err;
    logic [1:0]  off_cur, type_cur;
    logic [5:0]  wshift;
    logic [7:0]  be_wide;

    `ifdef LSU_MISALIGN_TRAP_EN
    logic mis_trap_q;
    assign trap_req = idle & lsu_req_i & split_cur;
    always_ff @(posedge clk_i) begin
        if (rst_i) mis_trap_q <= 1'b0;
        else       mis_trap_q <= trap_req;
    end
    assign trap_done = mis_trap_q;
    `else
    assign trap_req  = 1'b0;
    assign trap_done = 1'b0;
    `endif

    always_comb begin
        idle        = state_q == IDLE;
        wait_gnt    = (state_q == WAIT_GNT_MIS) || (state_q == WAIT_GNT);
        beat2       = split_q && ((state_q == WAIT_GNT) || (state_q == WAIT_RVALID));
        split_cur   = is_split(lsu_type_i, adder_result_ex_i[1:0]);
        accept      = idle & lsu_req_i & ~trap_req;
        gnt_timeout = (GNT_TIMEOUT != 0) && wait_gnt && (gnt_cnt_q == GNT_TIMEOUT);
        // In IDLE the bus is driven straight from EX so req goes out the same cycle.
        off_cur     = idle ? adder_result_ex_i[1:0] : off_q;
        type_cur    = idle ? lsu_type_i : type_q;
        wshift      = {1'b0, off_cur, 3'b000};
        be_wide     = {4'b0000, be_mask(type_cur)} << off_cur;
        rvalid_done = (state_q == WAIT_RVALID) & data_rvalid_i;
        beat1_err   = (state_q == WAIT_RVALID_MIS) & data_rvalid_i & data_err_i;
        bus_err     = (rvalid_done & data_err_i) | beat1_err | gnt_timeout;
    end

    assign data_req_o          = accept | (wait_gnt & ~gnt_timeout);
    assign data_addr_o         = {adder_result_ex_i[31:2], 2'b00};
    assign data_we_o           = idle ? lsu_we_i : we_q;
    assign data_be_o           = beat2 ? be_wide[7:4] : be_wide[3:0];
    assign data_wdata_o        = (lsu_wdata_i << wshift) | (lsu_wdata_i >> (6'd32 - wshift));
    assign lsu_addr_incr_req_o = (state_q == WAIT_RVALID_MIS) | beat2;
    assign addr_last_o         = addr_last_q;
    assign lsu_rdata_valid_o   = rvalid_done & ~data_err_i & ~we_q;
    assign lsu_req_done_o      = rvalid_done | beat1_err | gnt_timeout | trap_done;
    assign load_err_o          = bus_err & ~we_q;
    assign store_err_o         = bus_err & we_q;
    assign misaligned_err_o    = trap_done;
    assign busy_o              = ~idle;

    lsu_data_align u_align (
        .rdata_i    (data_rdata_i),
        .rdata_q_i  (rdata_q),
        .off_i      (off_q),
        .lsu_type_i (type_q),
        .split_i    (split_q),
        .sign_ext_i (sign_q),
        .rdata_o    (lsu_rdata_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_last_q <= 32'd0;
            rdata_q     <= 32'd0;
            gnt_cnt_q   <= 32'd0;
            type_q      <= LSU_WORD;
            off_q       <= 2'd0;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            split_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_last_q <= adder_result_ex_i;
                        type_q      <= lsu_type_i;
                        off_q       <= adder_result_ex_i[1:0];
                        we_q        <= lsu_we_i;
                        sign_q      <= lsu_sign_ext_i;
                        split_q     <= split_cur;
                        // The request cycle itself counts as the first cycle without grant.
                        gnt_cnt_q   <= data_gnt_i ? 32'd0 : 32'd1;
                        if (split_cur) state_q <= data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                        else           state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_GNT_MIS, WAIT_GNT: begin
                    if (gnt_timeout) begin
                        state_q   <= IDLE;
                        gnt_cnt_q <= 32'd0;
                    end else if (data_gnt_i) begin
                        gnt_cnt_q <= 32'd0;
                        state_q   <= (state_q == WAIT_GNT_MIS) ? WAIT_RVALID_MIS : WAIT_RVALID;
                    end else begin
                        gnt_cnt_q <= gnt_cnt_q + 32'd1;
                    end
                end
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            state_q <= IDLE;
                        end else begin
                            rdata_q <= data_rdata_i;
                            state_q <= WAIT_GNT;
                        end
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// tb/tb_lsu_split_ctrl.sv - directed vector bench for lsu_split_ctrl
module tb_lsu_split_ctrl;

    localparam logic [1:0] TW = 2'd0, TH = 2'd1, TB = 2'd2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sext = 1'b0;
    logic [1:0]  lsu_type = 2'd0;
    logic [31:0] lsu_wdata = 32'd0, ex_addr = 32'd0, adder;
    logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        req, we, incr, rdata_valid, done, load_err, store_err, mis_err, busy;
    logic [31:0] addr, wdata, addr_last, lsu_rdata;
    logic [3:0]  be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // EX stage model: operand muxes form addr_last+4 while the LSU asks for it.
    assign adder = incr ? addr_last + 32'd4 : ex_addr;

    lsu_split_ctrl #(.GNT_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
        .lsu_sign_ext_i(lsu_sext), .lsu_wdata_i(lsu_wdata), .adder_result_ex_i(adder),
        .data_req_o(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_err_i(err),
        .data_addr_o(addr), .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata),
        .data_rdata_i(rdata), .lsu_addr_incr_req_o(incr), .addr_last_o(addr_last),
        .lsu_rdata_o(lsu_rdata), .lsu_rdata_valid_o(rdata_valid), .lsu_req_done_o(done),
        .load_err_o(load_err), .store_err_o(store_err), .misaligned_err_o(mis_err),
        .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        split;
        logic [31:0] exp_addr1;
        logic [31:0] exp_addr2;
        logic [3:0]  exp_be1;
        logic [3:0]  exp_be2;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            we    typ sx  addr       wdata         rd1           rd2           sp  addr1      addr2      be1      be2      exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, TW, 0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 32'h100, 32'h0,   4'b1111, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, TW, 0, 32'h101, 32'h0,        32'h44332211, 32'h88776655, 1, 32'h100, 32'h104, 4'b1110, 4'b0001, 32'h0,        32'h55443322};
        vecs[2]  = '{1'b1, TH, 0, 32'h203, 32'h0000A5A5, 32'h0,        32'h0,        1, 32'h200, 32'h204, 4'b1000, 4'b0001, 32'hA50000A5, 32'h0};
        vecs[3]  = '{1'b0, TB, 1, 32'h302, 32'h0,        32'h00800000, 32'h0,        0, 32'h300, 32'h0,   4'b0100, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{1'b0, TB, 0, 32'h302, 32'h0,        32'h00800000, 32'h0,        0, 32'h300, 32'h0,   4'b0100, 4'b0000, 32'h0,        32'h00000080};
        vecs[5]  = '{1'b0, TH, 1, 32'h102, 32'h0,        32'h80011234, 32'h0,        0, 32'h100, 32'h0,   4'b1100, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{1'b0, TW, 0, 32'h10E, 32'h0,        32'hAABBCCDD, 32'h11223344, 1, 32'h10C, 32'h110, 4'b1100, 4'b0011, 32'h0,        32'h3344AABB};
        vecs[7]  = '{1'b1, TW, 0, 32'h013, 32'h12345678, 32'h0,        32'h0,        1, 32'h010, 32'h014, 4'b1000, 4'b0111, 32'h78123456, 32'h0};
        vecs[8]  = '{1'b0, TH, 0, 32'h207, 32'h0,        32'hCD000000, 32'h000000AB, 1, 32'h204, 32'h208, 4'b1000, 4'b0001, 32'h0,        32'h0000ABCD};
        vecs[9]  = '{1'b0, TH, 1, 32'h301, 32'h0,        32'h00FEDC00, 32'h0,        0, 32'h300, 32'h0,   4'b0110, 4'b0000, 32'h0,        32'hFFFFFEDC};
        vecs[10] = '{1'b1, TB, 0, 32'h401, 32'h0000005A, 32'h0,        32'h0,        0, 32'h400, 32'h0,   4'b0010, 4'b0000, 32'h00005A00, 32'h0};

        step; step;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_last", addr_last, 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_errs", {29'd0, load_err, store_err, mis_err}, 32'd0);
        step;
        rst = 1'b0;

        foreach (vecs[i]) begin
            step;
            lsu_req = 1'b1; lsu_we = vecs[i].we; lsu_type = vecs[i].typ;
            lsu_sext = vecs[i].sext; lsu_wdata = vecs[i].wdata; ex_addr = vecs[i].addr; gnt = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_req1", i), 32'(req), 32'd1);
            chk($sformatf("v%0d_addr1", i), addr, vecs[i].exp_addr1);
            chk($sformatf("v%0d_be1", i), 32'(be), 32'(vecs[i].exp_be1));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
            chk($sformatf("v%0d_wdata1", i), wdata, vecs[i].exp_wdata);
            step;
            lsu_req = 1'b0; gnt = 1'b0;
            if (vecs[i].split) begin
                rvalid = 1'b1; rdata = vecs[i].rd1;
                @(negedge clk);
                chk($sformatf("v%0d_incr_mis", i), 32'(incr), 32'd1);
                chk($sformatf("v%0d_req_mis", i), 32'(req), 32'd0);
                chk($sformatf("v%0d_done_mis", i), 32'(done), 32'd0);
                step;
                rvalid = 1'b0; gnt = 1'b1;
                @(negedge clk);
                chk($sformatf("v%0d_req2", i), 32'(req), 32'd1);
                chk($sformatf("v%0d_addr2", i), addr, vecs[i].exp_addr2);
                chk($sformatf("v%0d_be2", i), 32'(be), 32'(vecs[i].exp_be2));
                chk($sformatf("v%0d_incr2", i), 32'(incr), 32'd1);
                chk($sformatf("v%0d_wdata2", i), wdata, vecs[i].exp_wdata);
                step;
                gnt = 1'b0;
            end
            rvalid = 1'b1;
            rdata  = vecs[i].split ? vecs[i].rd2 : vecs[i].rd1;
            @(negedge clk);
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_rdata_valid", i), 32'(rdata_valid), 32'(!vecs[i].we));
            chk($sformatf("v%0d_errs", i), {29'd0, load_err, store_err, mis_err}, 32'd0);
            if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), lsu_rdata, vecs[i].exp_rdata);
            step;
            rvalid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_done_clr", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // Split load with bus error on beat 1: beat 2 must never be requested.
        step;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = TW; ex_addr = 32'h105; gnt = 1'b1;
        @(negedge clk);
        chk("err_be1", 32'(be), 32'b1110);
        step;
        lsu_req = 1'b0; gnt = 1'b0; rvalid = 1'b1; err = 1'b1; rdata = 32'h0;
        @(negedge clk);
        chk("err_done", 32'(done), 32'd1);
        chk("err_load_err", 32'(load_err), 32'd1);
        chk("err_store_err", 32'(store_err), 32'd0);
        chk("err_rdata_valid", 32'(rdata_valid), 32'd0);
        step;
        rvalid = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("err_no_beat2", 32'(req), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);

        // Grant timeout on a store: req for 4 cycles, then abort with store_err.
        step;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_type = TW; ex_addr = 32'h500;
        @(negedge clk);
        chk("to_req0", 32'(req), 32'd1);
        step;
        lsu_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_req%0d", k), 32'(req), 32'd1);
            chk($sformatf("to_done%0d", k), 32'(done), 32'd0);
            step;
        end
        @(negedge clk);
        chk("to_req_drop", 32'(req), 32'd0);
        chk("to_done", 32'(done), 32'd1);
        chk("to_store_err", 32'(store_err), 32'd1);
        chk("to_load_err", 32'(load_err), 32'd0);
        step;
        @(negedge clk);
        chk("to_idle", 32'(busy), 32'd0);

        // Grant arrives two cycles late, well inside the timeout.
        step;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = TW; ex_addr = 32'h600;
        @(negedge clk);
        chk("dg_req0", 32'(req), 32'd1);
        step;
        lsu_req = 1'b0;
        @(negedge clk);
        chk("dg_req1", 32'(req), 32'd1);
        chk("dg_addr1", addr, 32'h600);
        chk("dg_be1", 32'(be), 32'b1111);
        step;
        gnt = 1'b1;
        @(negedge clk);
        chk("dg_req2", 32'(req), 32'd1);
        step;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("dg_done", 32'(done), 32'd1);
        chk("dg_rdata", lsu_rdata, 32'h0BADF00D);
        step;
        rvalid = 1'b0;

        // Reset while waiting for rvalid; the late response must be ignored.
        step;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = TW; ex_addr = 32'h700; gnt = 1'b1;
        step;
        lsu_req = 1'b0; gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rr_busy", 32'(busy), 32'd1);
        step;
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rr_addr_last", addr_last, 32'd0);
        step;
        rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
